// File: rtl/lane_seg_top_mac_pipe.sv
// Pipelined signed multiply-accumulate for the lane_seg convolution datapath.
// Products are summed over an in_last-delimited frame; each frame yields one rounded, shifted, saturated result.
module lane_seg_top_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 14,
  parameter int ACC_WIDTH  = 40,
  parameter int DOUT_WIDTH = 16,
  parameter int OUT_SHIFT  = 8,
  parameter int NUM_STAGE  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_sat
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  if (ACC_WIDTH < PROD_WIDTH) begin : g_chk_acc
    $error("ACC_WIDTH must be at least DIN0_WIDTH+DIN1_WIDTH");
  end
  if (NUM_STAGE < 1) begin : g_chk_stage
    $error("NUM_STAGE must be at least 1");
  end
  if (OUT_SHIFT < 0 || OUT_SHIFT > ACC_WIDTH - 1) begin : g_chk_shift
    $error("OUT_SHIFT must lie in 0..ACC_WIDTH-1");
  end

  // Rounding constant is half an output LSB; it collapses to zero when OUT_SHIFT is 0.
  localparam logic signed [ACC_WIDTH:0] RND  = ((ACC_WIDTH+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_WIDTH:0] DMAX =
    {{(ACC_WIDTH+2-DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] DMIN = ~DMAX;

  logic signed [PROD_WIDTH-1:0] m_prod [NUM_STAGE];
  logic        [NUM_STAGE-1:0]  m_valid;
  logic        [NUM_STAGE-1:0]  m_last;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH-1:0]  a_sum;
  logic                         a_valid;

  logic signed [ACC_WIDTH:0]    ext;
  logic signed [ACC_WIDTH:0]    rnd;
  logic                         over;
  logic                         under;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= '0;
      m_last  <= '0;
    end else if (ce) begin
      m_prod[0]  <= PROD_WIDTH'(din0) * PROD_WIDTH'(din1);
      m_valid[0] <= in_valid;
      m_last[0]  <= in_valid & in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        m_prod[i]  <= m_prod[i-1];
        m_valid[i] <= m_valid[i-1];
        m_last[i]  <= m_last[i-1];
      end
    end
  end

  always_comb begin
    acc_sum = acc + ACC_WIDTH'(m_prod[NUM_STAGE-1]);
  end

  // The final term clears the accumulator so the next frame can start on the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      a_sum   <= '0;
      a_valid <= 1'b0;
    end else if (ce) begin
      a_valid <= m_valid[NUM_STAGE-1] & m_last[NUM_STAGE-1];
      if (m_valid[NUM_STAGE-1]) begin
        if (m_last[NUM_STAGE-1]) begin
          acc   <= '0;
          a_sum <= acc_sum;
        end else begin
          acc   <= acc_sum;
        end
      end
    end
  end

  // One guard bit keeps the rounding add from overflowing before saturation.
  always_comb begin
    ext   = {a_sum[ACC_WIDTH-1], a_sum};
    rnd   = (ext + RND) >>> OUT_SHIFT;
    over  = rnd > DMAX;
    under = rnd < DMIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      out_valid <= a_valid;
      if (a_valid) begin
        dout    <= over ? DMAX[DOUT_WIDTH-1:0] : (under ? DMIN[DOUT_WIDTH-1:0] : rnd[DOUT_WIDTH-1:0]);
        out_sat <= over | under;
      end
    end
  end

endmodule
